// File: rtl/mult_issue_ctrl.sv
// Issue/collect sequencer in front of the shift-add multiplier: accepts operand
// pairs, pulses init, waits for done (with timeout) and presents the product.
module mult_issue_ctrl #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               err,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_init,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_pp
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ARM  = 3'd1;
    localparam logic [2:0] FIRE = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] HOLD = 3'd4;

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_MAX   = '1;

    logic [2:0]    state;
    logic [TW-1:0] timer;

    // Handshake and init are pure state decodes so no input reaches an output.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign mul_init  = (state == FIRE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            mul_a  <= '0;
            mul_b  <= '0;
            result <= '0;
            timer  <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mul_a <= op_a;
                        mul_b <= op_b;
                        err   <= 1'b0;
                        // A zero operand makes the product trivially zero; skip the multiplier.
                        if (op_a == '0 || op_b == '0) begin
                            result <= '0;
                            state  <= HOLD;
                        end else begin
                            state <= ARM;
                        end
                    end
                end
                ARM: begin
                    // A done still held from the previous job must drain before we fire.
                    if (!mul_done) state <= FIRE;
                end
                FIRE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (timer != T_MAX) timer <= timer + 1'b1;
                    if (mul_done) begin
                        result <= mul_pp;
                        state  <= HOLD;
                    end else if (timer == TO_LAST) begin
                        result <= '0;
                        err    <= 1'b1;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl with a behavioural shift-add multiplier model
// (fixed latency, configurable done-hold length, optional hang).
module tb_mult_issue_ctrl;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 8;
    localparam int TW      = 8;
    localparam int LAT     = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic               err;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_init;
    logic               mul_done = 1'b0;
    logic [2*WIDTH-1:0] mul_pp   = '0;

    mult_issue_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .err(err),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_init(mul_init), .mul_done(mul_done), .mul_pp(mul_pp)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Multiplier model: done rises LAT cycles after init and is held done_hold cycles.
    int done_hold = 2;
    bit hang      = 1'b0;
    int cnt       = 0;
    int hold      = 0;
    bit run       = 1'b0;

    always @(posedge clk) begin
        if (mul_init) begin
            run      <= 1'b1;
            cnt      <= LAT;
            hold     <= 0;
            mul_done <= 1'b0;
        end else if (run) begin
            if (cnt == 1) begin
                run <= 1'b0;
                if (!hang) begin
                    mul_done <= 1'b1;
                    hold     <= done_hold;
                    mul_pp   <= {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
                end
            end else begin
                cnt <= cnt - 1;
            end
        end else if (hold > 1) begin
            hold <= hold - 1;
        end else if (hold == 1) begin
            hold     <= 0;
            mul_done <= 1'b0;
        end
    end

    // Init must be a single-cycle pulse, issued only after done was seen low.
    int   init_pulses = 0;
    int   init_bad    = 0;
    logic prev_init   = 1'b0;
    logic prev_done   = 1'b0;

    always @(negedge clk) begin
        if (mul_init) begin
            init_pulses <= init_pulses + 1;
            if (prev_init || prev_done || mul_done) init_bad <= init_bad + 1;
        end
        prev_init <= mul_init;
        prev_done <= mul_done;
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // cyc counts negedges from the one right after the accept edge (=1).
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    int cyc;
    int p0;

    initial begin
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b0;
        rst       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_mul_init", mul_init, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        check("rst_mul_a", mul_a, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // Single job 300*7
        p0 = init_pulses;
        send(16'd300, 16'd7);
        check("j1_in_ready_busy", in_ready, 0);
        check("j1_mul_a", mul_a, 300);
        check("j1_mul_b", mul_b, 7);
        wait_out(cyc);
        check("j1_valid", out_valid, 1);
        check("j1_latency", cyc, 8);
        check("j1_result", result, 32'h834);
        check("j1_err", err, 0);
        check("j1_init_pulses", init_pulses - p0, 1);
        // Backpressure: five cycles without out_ready
        repeat (5) @(negedge clk);
        check("bp_valid", out_valid, 1);
        check("bp_result", result, 32'h834);
        check("bp_in_ready", in_ready, 0);
        consume();
        check("j1_valid_drop", out_valid, 0);
        check("j1_in_ready_back", in_ready, 1);

        // Max operands
        repeat (6) @(negedge clk);
        send(16'hFFFF, 16'hFFFF);
        wait_out(cyc);
        check("max_latency", cyc, 8);
        check("max_result", result, 32'hFFFE0001);
        consume();

        // Zero bypass
        repeat (6) @(negedge clk);
        p0 = init_pulses;
        send(16'h0000, 16'h1234);
        check("zero_valid", out_valid, 1);
        check("zero_result", result, 0);
        check("zero_err", err, 0);
        check("zero_mul_b", mul_b, 16'h1234);
        consume();
        repeat (4) @(negedge clk);
        check("zero_no_init", init_pulses - p0, 0);

        // Back-to-back with done held 10 cycles
        done_hold = 10;
        repeat (4) @(negedge clk);
        send(16'd3, 16'd4);
        wait_out(cyc);
        check("b2b_a_latency", cyc, 8);
        check("b2b_a_result", result, 12);
        consume();
        send(16'd5, 16'd6);
        wait_out(cyc);
        check("b2b_b_latency", cyc, 15);
        check("b2b_b_result", result, 30);
        consume();
        done_hold = 2;
        repeat (15) @(negedge clk);
        check("b2b_done_low", mul_done, 0);

        // Timeout: multiplier never signals done
        hang = 1'b1;
        send(16'd9, 16'd9);
        wait_out(cyc);
        check("to_valid", out_valid, 1);
        check("to_latency", cyc, 11);
        check("to_err", err, 1);
        check("to_result", result, 0);
        consume();
        hang = 1'b0;
        repeat (2) @(negedge clk);
        send(16'd2, 16'd3);
        check("to_err_cleared", err, 0);
        wait_out(cyc);
        check("after_to_result", result, 6);
        check("after_to_err", err, 0);
        consume();

        // Reset during WAIT
        repeat (5) @(negedge clk);
        send(16'd7, 16'd8);
        @(negedge clk);
        check("mid_fire", mul_init, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_mul_init", mul_init, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_mul_a", mul_a, 0);
        check("mid_rst_mul_b", mul_b, 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        send(16'd10, 16'd10);
        wait_out(cyc);
        check("post_rst_result", result, 100);
        consume();

        check("init_order", init_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
